// File: rtl/ship_pkg.sv
// Shared constants, colours and bullet FSM encoding for the player ship block.
package ship_pkg;

  localparam logic [10:0] H_RES       = 11'd640;
  localparam logic [10:0] V_RES       = 11'd480;
  localparam logic [10:0] SHIP_Y      = 11'd448;
  localparam logic [10:0] SHIP_W      = 11'd16;
  localparam logic [10:0] SHIP_H      = 11'd16;
  localparam logic [10:0] BULLET_W    = 11'd2;
  localparam logic [10:0] BULLET_H    = 11'd8;
  localparam logic [10:0] SHIP_X_RST  = 11'd312;
  localparam logic [10:0] BULLET_XOFF = 11'd7;

  localparam logic [2:0] RGB_OFF    = 3'b000;
  localparam logic [2:0] RGB_SHIP   = 3'b010;
  localparam logic [2:0] RGB_BULLET = 3'b110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FLY  = 1'b1
  } bullet_state_e;

endpackage

// File: rtl/ship_unit_rom.sv
// 16x16 ship bitmap; bit 15 of each row is the leftmost column.
module ship_rom (
  input  logic [3:0]  row,
  output logic [15:0] data
);

  // Row lookup
  always_comb begin
    case (row)
      4'd0:    data = 16'h0180;
      4'd1:    data = 16'h0180;
      4'd2:    data = 16'h03C0;
      4'd3:    data = 16'h03C0;
      4'd4:    data = 16'h07E0;
      4'd5:    data = 16'h07E0;
      4'd6:    data = 16'h0FF0;
      4'd7:    data = 16'h1FF8;
      4'd8:    data = 16'h3FFC;
      4'd9:    data = 16'h7FFE;
      4'd10:   data = 16'hFFFF;
      4'd11:   data = 16'hFFFF;
      4'd12:   data = 16'hFFFF;
      4'd13:   data = 16'hE7E7;
      4'd14:   data = 16'hC3C3;
      4'd15:   data = 16'h8181;
      default: data = 16'h0000;
    endcase
  end

endmodule

// File: rtl/ship_unit.sv
// Player ship and single bullet: button sync, per-frame motion, bullet FSM
// and pixel-level object colour generation.
module ship_unit
  import ship_pkg::*;
#(
  parameter logic [10:0] H_RES       = ship_pkg::H_RES,
  parameter logic [10:0] V_RES       = ship_pkg::V_RES,
  parameter logic [10:0] SHIP_Y      = ship_pkg::SHIP_Y,
  parameter logic [10:0] SHIP_STEP   = 11'd4,
  parameter logic [10:0] BULLET_STEP = 11'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_fire,
  input  logic        hit,
  output logic [10:0] ship_x,
  output logic [10:0] bullet_x,
  output logic [10:0] bullet_y,
  output logic        bullet_active,
  output logic        frame_tick,
  output logic        obj_on,
  output logic [2:0]  rgb
);

  localparam logic [10:0] SHIP_X_MAX = H_RES - SHIP_W;
  localparam logic [10:0] BULLET_Y0  = SHIP_Y - BULLET_H;

  logic [2:0]    btn_meta_r, btn_sync_r;
  logic          fire_prev_r, fire_req_r, frame_tick_r;
  logic [10:0]   ship_x_r, bullet_x_r, bullet_y_r;
  bullet_state_e state_r, state_s;
  logic [10:0]   ship_x_s, bullet_x_s, bullet_y_s;
  logic          fire_req_s, frame_s, fire_edge_s;
  logic          left_s, right_s;
  logic [10:0]   ship_dx_s, ship_dy_s, bul_dx_s, bul_dy_s;
  logic [15:0]   rom_data_s;
  logic          ship_on_s, bullet_on_s;

  assign left_s      = btn_sync_r[0];
  assign right_s     = btn_sync_r[1];
  assign fire_edge_s = btn_sync_r[2] & ~fire_prev_r;
  assign frame_s     = p_tick && (pixel_x == 11'd0) && (pixel_y == V_RES);

  // Button synchronizers, fire edge history and frame strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta_r   <= 3'b000;
      btn_sync_r   <= 3'b000;
      fire_prev_r  <= 1'b0;
      frame_tick_r <= 1'b0;
    end else begin
      btn_meta_r   <= {btn_fire, btn_right, btn_left};
      btn_sync_r   <= btn_meta_r;
      fire_prev_r  <= btn_sync_r[2];
      frame_tick_r <= frame_s;
    end
  end

  // Ship motion; compare before subtracting so the position never wraps
  always_comb begin
    ship_x_s = ship_x_r;
    if (frame_tick_r) begin
      case ({left_s, right_s})
        2'b10:   ship_x_s = (ship_x_r < SHIP_STEP) ? 11'd0 : ship_x_r - SHIP_STEP;
        2'b01:   ship_x_s = (ship_x_r > SHIP_X_MAX - SHIP_STEP) ? SHIP_X_MAX
                                                                : ship_x_r + SHIP_STEP;
        default: ship_x_s = ship_x_r;
      endcase
    end else begin
      ship_x_s = ship_x_r;
    end
  end

  // Bullet FSM next state; hit outranks a coincident frame tick
  always_comb begin
    state_s    = state_r;
    bullet_x_s = bullet_x_r;
    bullet_y_s = bullet_y_r;
    fire_req_s = fire_req_r;
    case (state_r)
      ST_IDLE: begin
        if (frame_tick_r && fire_req_r) begin
          state_s    = ST_FLY;
          bullet_x_s = ship_x_r + BULLET_XOFF;
          bullet_y_s = BULLET_Y0;
          fire_req_s = 1'b0;
        end else if (fire_edge_s) begin
          fire_req_s = 1'b1;
        end else begin
          fire_req_s = fire_req_r;
        end
      end
      ST_FLY: begin
        fire_req_s = 1'b0;
        if (hit) begin
          state_s = ST_IDLE;
        end else if (frame_tick_r) begin
          if (bullet_y_r < BULLET_STEP) begin
            state_s = ST_IDLE;
          end else begin
            bullet_y_s = bullet_y_r - BULLET_STEP;
          end
        end else begin
          state_s = ST_FLY;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        fire_req_s = 1'b0;
      end
    endcase
  end

  // Position and FSM state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ship_x_r   <= SHIP_X_RST;
      bullet_x_r <= 11'd0;
      bullet_y_r <= 11'd0;
      state_r    <= ST_IDLE;
      fire_req_r <= 1'b0;
    end else begin
      ship_x_r   <= ship_x_s;
      bullet_x_r <= bullet_x_s;
      bullet_y_r <= bullet_y_s;
      state_r    <= state_s;
      fire_req_r <= fire_req_s;
    end
  end

  assign ship_dx_s = pixel_x - ship_x_r;
  assign ship_dy_s = pixel_y - SHIP_Y;
  assign bul_dx_s  = pixel_x - bullet_x_r;
  assign bul_dy_s  = pixel_y - bullet_y_r;

  ship_rom u_rom (
    .row  (ship_dy_s[3:0]),
    .data (rom_data_s)
  );

  // Object hit tests and colour priority
  always_comb begin
    ship_on_s   = (pixel_x >= ship_x_r) && (ship_dx_s < SHIP_W) &&
                  (pixel_y >= SHIP_Y) && (ship_dy_s < SHIP_H) &&
                  rom_data_s[4'd15 - ship_dx_s[3:0]];
    bullet_on_s = (state_r == ST_FLY) &&
                  (pixel_x >= bullet_x_r) && (bul_dx_s < BULLET_W) &&
                  (pixel_y >= bullet_y_r) && (bul_dy_s < BULLET_H);
    if (!video_on) begin
      rgb = RGB_OFF;
    end else if (ship_on_s) begin
      rgb = RGB_SHIP;
    end else if (bullet_on_s) begin
      rgb = RGB_BULLET;
    end else begin
      rgb = RGB_OFF;
    end
    obj_on = video_on & (ship_on_s | bullet_on_s);
  end

  assign ship_x        = ship_x_r;
  assign bullet_x      = bullet_x_r;
  assign bullet_y      = bullet_y_r;
  assign bullet_active = (state_r == ST_FLY);
  assign frame_tick    = frame_tick_r;

endmodule
